four_bit_adder_accumulator: RTL and testbench

FOUR_BIT_ADDER_ACCUMULATOR -- requirements
Module: four_bit_adder_accumulator

---
 rtl/four_bit_adder_accumulator_pkg.sv | 15 +
 rtl/four_bit_adder_accumulator_adder.sv | 12 +
 rtl/four_bit_adder_accumulator.sv | 114 +++++++++++
 tb/tb_four_bit_adder_accumulator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/four_bit_adder_accumulator_pkg.sv
// Shared constants for the 4-bit adder/accumulator: FSM encoding, datapath
// widths and the default batch length.
package four_bit_adder_accumulator_pkg;

    localparam int ACC_W         = 8;
    localparam int OP_W          = 4;
    localparam int BATCH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_adder_accumulator_adder.sv
// Combinational 8-bit + 4-bit adder; bit 8 of the sum is the carry out.
module adder_8x4_carry
    import four_bit_adder_accumulator_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic [OP_W-1:0]  i_addend,
    output logic [ACC_W:0]   o_sum
);

    assign o_sum = {1'b0, i_acc} + {{(ACC_W-OP_W+1){1'b0}}, i_addend};

endmodule

// File: rtl/four_bit_adder_accumulator.sv
// Batch accumulator: sums BATCH 4-bit operands into an 8-bit result with a
// sticky carry flag, then holds the result until the consumer takes it.
module four_bit_adder_accumulator
    import four_bit_adder_accumulator_pkg::*;
#(
    parameter int BATCH = BATCH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  a,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [7:0]       op_count
);

    localparam logic [7:0] BATCH_C = 8'(BATCH);

    state_t             r_state;
    logic [ACC_W-1:0]   r_result;
    logic               r_overflow;
    logic [7:0]         r_op_count;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_result_nxt;
    logic               w_overflow_nxt;
    logic [7:0]         w_op_count_nxt;
    logic [7:0]         w_cnt_inc;
    logic [ACC_W:0]     w_sum;
    logic               w_accept;

    adder_8x4_carry u_adder (
        .i_acc    (r_result),
        .i_addend (a),
        .o_sum    (w_sum)
    );

    // Handshake outputs are pure state decodes, so a/in_valid never reach an output.
    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign op_count  = r_op_count;

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_op_count + 8'd1;

    // Next-state and datapath update; clear outranks both accept and out_ready.
    always_comb begin
        w_state_nxt    = r_state;
        w_result_nxt   = r_result;
        w_overflow_nxt = r_overflow;
        w_op_count_nxt = r_op_count;
        if (clear) begin
            w_state_nxt    = ST_IDLE;
            w_result_nxt   = 8'h00;
            w_overflow_nxt = 1'b0;
            w_op_count_nxt = 8'h00;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        w_result_nxt   = w_sum[ACC_W-1:0];
                        w_overflow_nxt = r_overflow | w_sum[ACC_W];
                        w_op_count_nxt = w_cnt_inc;
                        if (w_cnt_inc == BATCH_C) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_ACCUM;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_nxt    = ST_IDLE;
                        w_result_nxt   = 8'h00;
                        w_overflow_nxt = 1'b0;
                        w_op_count_nxt = 8'h00;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_result_nxt   = 8'h00;
                    w_overflow_nxt = 1'b0;
                    w_op_count_nxt = 8'h00;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset to an empty IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_result   <= 8'h00;
            r_overflow <= 1'b0;
            r_op_count <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_result   <= w_result_nxt;
            r_overflow <= w_overflow_nxt;
            r_op_count <= w_op_count_nxt;
        end
    end

endmodule

// File: tb/tb_four_bit_adder_accumulator.sv
// Scoreboard bench: three instances (BATCH=4, 20, 1); expected batch results are
// queued by the stimulus and popped by a monitor on each out_valid/out_ready handshake.
module tb_four_bit_adder_accumulator;

    typedef struct {
        int         d;
        logic [7:0] res;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst  [3];
    logic [3:0] a    [3];
    logic       iv   [3];
    logic       ir   [3];
    logic       clr  [3];
    logic [7:0] res  [3];
    logic       ov   [3];
    logic       ordy [3];
    logic       ovf  [3];
    logic [7:0] cnt  [3];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    four_bit_adder_accumulator #(.BATCH(4)) u_b4 (
        .clk(clk), .rst(rst[0]), .a(a[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .clear(clr[0]), .result(res[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .overflow(ovf[0]), .op_count(cnt[0]));

    four_bit_adder_accumulator #(.BATCH(20)) u_b20 (
        .clk(clk), .rst(rst[1]), .a(a[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .clear(clr[1]), .result(res[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .overflow(ovf[1]), .op_count(cnt[1]));

    four_bit_adder_accumulator #(.BATCH(1)) u_b1 (
        .clk(clk), .rst(rst[2]), .a(a[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .clear(clr[2]), .result(res[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .overflow(ovf[2]), .op_count(cnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] r, input logic o, input logic [7:0] c);
        exp_t e;
        e.d = d; e.res = r; e.ovf = o; e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic feed(input int d, input logic [3:0] v);
        a[d]  = v;
        iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d] === 1'b1 && ordy[d] === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].d != d) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_out dut%0d: got result %0h with no queued expectation", d, res[d]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("d%0d_result", d), 32'(res[d]), 32'(e.res));
                    chk($sformatf("d%0d_overflow", d), 32'(ovf[d]), 32'(e.ovf));
                    chk($sformatf("d%0d_op_count", d), 32'(cnt[d]), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; a[d] = 4'h0; iv[d] = 1'b0; clr[d] = 1'b0;
        end
        ordy[0] = 1'b1; ordy[1] = 1'b0; ordy[2] = 1'b0;
        #3;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_result%0d", d),    32'(res[d]), 32'h0);
            chk($sformatf("rst_overflow%0d", d),  32'(ovf[d]), 32'h0);
            chk($sformatf("rst_op_count%0d", d),  32'(cnt[d]), 32'h0);
            chk($sformatf("rst_out_valid%0d", d), 32'(ov[d]),  32'h0);
            chk($sformatf("rst_in_ready%0d", d),  32'(ir[d]),  32'h1);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Basic batch on BATCH=4, accepted from the first edge after reset.
        push(0, 8'h10, 1'b0, 8'd4);
        feed(0, 4'd3); feed(0, 4'd5); feed(0, 4'd7); feed(0, 4'd1);
        chk("basic_out_valid", 32'(ov[0]), 32'h1);
        @(posedge clk); #1;
        chk("basic_idle_result", 32'(res[0]), 32'h0);
        chk("basic_idle_out_valid", 32'(ov[0]), 32'h0);
        chk("basic_idle_in_ready", 32'(ir[0]), 32'h1);
        chk("basic_idle_op_count", 32'(cnt[0]), 32'h0);

        // Backpressure: held result, extra operands ignored.
        ordy[0] = 1'b0;
        push(0, 8'h3C, 1'b0, 8'd4);
        repeat (4) feed(0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            a[0] = 4'hF; iv[0] = 1'b1;
            chk("bp_out_valid", 32'(ov[0]), 32'h1);
            chk("bp_in_ready", 32'(ir[0]), 32'h0);
            chk("bp_result", 32'(res[0]), 32'h3C);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        chk("bp_op_count", 32'(cnt[0]), 32'd4);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_result", 32'(res[0]), 32'h0);
        chk("bp_idle_in_ready", 32'(ir[0]), 32'h1);

        // Clear beats a simultaneous accept.
        feed(0, 4'd2); feed(0, 4'd6);
        chk("clr_pre_op_count", 32'(cnt[0]), 32'd2);
        chk("clr_pre_result", 32'(res[0]), 32'h08);
        a[0] = 4'd9; iv[0] = 1'b1; clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0; iv[0] = 1'b0;
        chk("clr_result", 32'(res[0]), 32'h0);
        chk("clr_op_count", 32'(cnt[0]), 32'h0);
        chk("clr_in_ready", 32'(ir[0]), 32'h1);
        chk("clr_out_valid", 32'(ov[0]), 32'h0);
        push(0, 8'h04, 1'b0, 8'd4);
        repeat (4) feed(0, 4'd1);
        @(posedge clk); #1;

        // Asynchronous reset in DONE discards the result.
        ordy[0] = 1'b0;
        feed(0, 4'd3); feed(0, 4'd5); feed(0, 4'd7); feed(0, 4'd1);
        chk("ar_done_result", 32'(res[0]), 32'h10);
        chk("ar_done_out_valid", 32'(ov[0]), 32'h1);
        #3;
        rst[0] = 1'b1;
        #1;
        chk("ar_result", 32'(res[0]), 32'h0);
        chk("ar_op_count", 32'(cnt[0]), 32'h0);
        chk("ar_out_valid", 32'(ov[0]), 32'h0);
        chk("ar_in_ready", 32'(ir[0]), 32'h1);
        #1;
        rst[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_after_out_valid", 32'(ov[0]), 32'h0);

        // Overflow on BATCH=20: 18 x 0xF = 270 -> 0x0E with carry.
        repeat (18) feed(1, 4'hF);
        chk("ovf_result", 32'(res[1]), 32'h0E);
        chk("ovf_flag", 32'(ovf[1]), 32'h1);
        chk("ovf_op_count", 32'(cnt[1]), 32'd18);
        push(1, 8'h0E, 1'b1, 8'd20);
        feed(1, 4'h0); feed(1, 4'h0);
        chk("ovf_done_valid", 32'(ov[1]), 32'h1);
        chk("ovf_done_flag", 32'(ovf[1]), 32'h1);
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        chk("ovf_idle_flag", 32'(ovf[1]), 32'h0);
        chk("ovf_idle_result", 32'(res[1]), 32'h0);

        // BATCH=1: in_valid held through DONE is not taken until released.
        push(2, 8'h0A, 1'b0, 8'd1);
        a[2] = 4'hA; iv[2] = 1'b1;
        @(posedge clk); #1;
        chk("b1_out_valid", 32'(ov[2]), 32'h1);
        chk("b1_result", 32'(res[2]), 32'h0A);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("b1_hold_op_count", 32'(cnt[2]), 32'd1);
            chk("b1_hold_in_ready", 32'(ir[2]), 32'h0);
        end
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        chk("b1_idle_out_valid", 32'(ov[2]), 32'h0);
        chk("b1_idle_op_count", 32'(cnt[2]), 32'h0);
        push(2, 8'h0A, 1'b0, 8'd1);
        @(posedge clk); #1;
        iv[2] = 1'b0;
        chk("b1_again_out_valid", 32'(ov[2]), 32'h1);
        @(posedge clk); #1;
        chk("b1_final_out_valid", 32'(ov[2]), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_expectations", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
